sifh_hist_seq: RTL and testbench
================================

SIFH_HIST_SEQ -- requirements
Module: sifh_hist_seq

Interface
REQ-001 SHALL have parameter NB, default 8: histogram bin address width; the RAM depth is 2^NB.
REQ-002 SHALL have parameter PEAK_W, default 12: bin count width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port res, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a measurement; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: returns the block to IDLE from any state.
REQ-007 SHALL have port acq_cycles, input, 24 bits: acquisition window length; latched on an accepted start.
REQ-008 SHALL have port tdc_valid, input, 1 bit: a timestamp event is present this cycle.
REQ-009 SHALL have port tdc_bin, input, NB bits: bin index of the event.
REQ-010 SHALL have ports waddr (NB), wdata (PEAK_W) and wen (1), outputs: the RAM write port A.
REQ-011 SHALL have ports raddr (NB) and ren (1), outputs, and rdata (PEAK_W), input: the RAM read port B; rdata is valid 1 cycle after ren.
REQ-012 SHALL have outputs busy (1), done (1), peak_bin (NB), peak_count (PEAK_W) and ovf (1).

Function
REQ-013 SHALL implement the states IDLE, CLEAR, ACQ, DRAIN, SCAN and DONE.
REQ-014 SHALL go from IDLE to CLEAR on start; busy SHALL be 1 in every state except IDLE.
REQ-015 SHALL, in CLEAR, write wdata=0 to addresses 0..2^NB-1 on consecutive cycles (2^NB cycles), then enter ACQ.
REQ-016 SHALL stay in ACQ for exactly acq_cycles cycles; if acq_cycles=0, SHALL go from CLEAR directly to DRAIN.
REQ-017 SHALL, in ACQ, accept every cycle with tdc_valid=1 as one event; tdc_valid SHALL be ignored in all other states.
REQ-018 SHALL process each accepted event as a read-modify-write pipeline: read tdc_bin, then 1 cycle later write old+1 to the same bin.
REQ-019 SHALL forward in-flight write data so that N accepted events to one bin, at any spacing including back-to-back, yield a count of exactly N.
REQ-020 SHALL saturate a count at 2^PEAK_W-1 and then set ovf; ovf SHALL be sticky until the next accepted start.
REQ-021 SHALL stay in DRAIN until all pending writes complete (at most 2 cycles), then enter SCAN.
REQ-022 SHALL, in SCAN, read bins 0..2^NB-1 in order and track the maximum.
REQ-023 SHALL replace the tracked maximum only on a strictly greater count, so the lowest bin wins ties; an all-zero histogram SHALL give peak_bin=0 and peak_count=0.
REQ-024 SHALL enter DONE after the last SCAN read data returns, assert done for exactly 1 cycle, then return to IDLE.
REQ-025 SHALL hold peak_bin and peak_count from done until the next accepted start.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL, on abort in a non-IDLE state, go to IDLE on the next edge with wen=0 and ren=0, no done pulse, and peak outputs unchanged.
REQ-028 SHALL let abort win when start and abort are asserted together in IDLE.
REQ-029 SHALL drive wen only in CLEAR, ACQ and DRAIN, and ren only in ACQ and SCAN.

Reset
REQ-030 SHALL, on res=0, asynchronously force the state to IDLE.
REQ-031 SHALL, on res=0, clear busy, done, wen, ren, waddr, raddr, wdata, peak_bin, peak_count, ovf, the cycle counter and the pipeline valid bits to 0.
REQ-032 SHALL, on a reset mid-measurement, discard the histogram and require a new start; no done pulse is produced.

Structure
REQ-033 SHALL take the state encoding and the NB and PEAK_W defaults from the shared package sifh_pkg.
REQ-034 SHALL place the max compare/register logic in the sub-module sifh_peak_tracker (inputs clear, valid, bin, count; outputs peak_bin, peak_count).
REQ-035 SHALL leave the RAM itself outside this block.

Verification
REQ-036 SHALL cover: NB=4, start, acq_cycles=0 -> 16 CLEAR writes of 0, no ACQ writes, done with peak_bin=0 and peak_count=0.
REQ-037 SHALL cover: 5 back-to-back events to bin 3, then 2 events to bin 7 spaced 3 cycles apart -> bin 3=5, bin 7=2, peak_bin=3, peak_count=5.
REQ-038 SHALL cover: bin 2 and bin 9 each hit 4 times -> peak_bin=2 (tie goes to the lowest bin).
REQ-039 SHALL cover: PEAK_W=3 with 10 events to bin 1 -> count saturates at 7, ovf=1, peak_count=7.
REQ-040 SHALL cover: abort mid-ACQ -> IDLE on the next cycle, no done, wen=0; a following start runs a full fresh measurement.
REQ-041 SHALL cover: start pulsed during SCAN is ignored; res pulsed low during SCAN forces IDLE with all outputs at 0.

Source files
------------

// File: rtl/sifh_pkg.sv
// Shared definitions for the histogram sequencer: parameter defaults and FSM state encoding.
package sifh_pkg;

  localparam int unsigned NbDefault    = 8;
  localparam int unsigned PeakWDefault = 12;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAcq,
    StDrain,
    StScan,
    StDone
  } sifh_state_e;

endpackage

// File: rtl/sifh_peak_tracker.sv
// Running maximum over scanned bins; strictly-greater update keeps the lowest bin on ties.
module sifh_peak_tracker
  import sifh_pkg::*;
#(
  parameter int unsigned NB     = NbDefault,
  parameter int unsigned PEAK_W = PeakWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [NB-1:0]     bin,
  input  logic [PEAK_W-1:0] count,
  output logic [NB-1:0]     peak_bin,
  output logic [PEAK_W-1:0] peak_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (clear) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (valid && (count > peak_count)) begin
      peak_bin   <= bin;
      peak_count <= count;
    end
  end

endmodule

// File: rtl/sifh_hist_seq.sv
// Histogram sequencer: clears an external RAM, accumulates timestamp bins with a
// forwarded read-modify-write pipeline, then scans for the peak bin.
module sifh_hist_seq
  import sifh_pkg::*;
#(
  parameter int unsigned NB     = NbDefault,
  parameter int unsigned PEAK_W = PeakWDefault
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              abort,
  input  logic [23:0]       acq_cycles,
  input  logic              tdc_valid,
  input  logic [NB-1:0]     tdc_bin,
  output logic [NB-1:0]     waddr,
  output logic [PEAK_W-1:0] wdata,
  output logic              wen,
  output logic [NB-1:0]     raddr,
  output logic              ren,
  input  logic [PEAK_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [NB-1:0]     peak_bin,
  output logic [PEAK_W-1:0] peak_count,
  output logic              ovf
);

  sifh_state_e state_q, state_d;

  // idx carries one extra bit so SCAN can spend a cycle waiting on the last read.
  logic [NB:0]       idx_q, idx_d;
  logic [23:0]       acq_q, acq_d;
  logic              p_valid_q;
  logic [NB-1:0]     p_bin_q;
  logic              fw_valid_q;
  logic [NB-1:0]     fw_bin_q;
  logic [PEAK_W-1:0] fw_data_q;
  logic              s_valid_q;
  logic [NB-1:0]     s_bin_q;
  logic              ovf_q;

  logic              start_ok;
  logic              accept;
  logic              rmw_wen;
  logic [PEAK_W-1:0] base;
  logic              at_max;
  logic [PEAK_W-1:0] inc_data;

  assign start_ok = (state_q == StIdle) && start && !abort;
  assign accept   = (state_q == StAcq) && tdc_valid && !abort;
  assign rmw_wen  = p_valid_q && !abort;

  // The write issued last cycle lands in RAM on the same edge as this read, so forward it.
  assign base     = (fw_valid_q && (fw_bin_q == p_bin_q)) ? fw_data_q : rdata;
  assign at_max   = &base;
  assign inc_data = at_max ? base : base + PEAK_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acq_d   = acq_q;
    wen     = 1'b0;
    waddr   = '0;
    wdata   = '0;
    ren     = 1'b0;
    raddr   = '0;
    busy    = (state_q != StIdle);
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StClear;
          idx_d   = '0;
          acq_d   = acq_cycles;
        end
      end
      StClear: begin
        wen   = 1'b1;
        waddr = idx_q[NB-1:0];
        idx_d = idx_q + 1'b1;
        if (idx_q[NB-1:0] == {NB{1'b1}}) begin
          idx_d   = '0;
          state_d = (acq_q == '0) ? StDrain : StAcq;
        end
      end
      StAcq: begin
        if (tdc_valid) begin
          ren   = 1'b1;
          raddr = tdc_bin;
        end
        acq_d = acq_q - 24'd1;
        if (acq_q == 24'd1) state_d = StDrain;
      end
      StDrain: begin
        if (!p_valid_q) state_d = StScan;
      end
      StScan: begin
        if (!idx_q[NB]) begin
          ren   = 1'b1;
          raddr = idx_q[NB-1:0];
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // p_valid_q can only be set while in ACQ or DRAIN.
    if (p_valid_q) begin
      wen   = 1'b1;
      waddr = p_bin_q;
      wdata = inc_data;
    end

    if (abort) begin
      state_d = StIdle;
      wen     = 1'b0;
      waddr   = '0;
      wdata   = '0;
      ren     = 1'b0;
      raddr   = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acq_q      <= '0;
      p_valid_q  <= 1'b0;
      p_bin_q    <= '0;
      fw_valid_q <= 1'b0;
      fw_bin_q   <= '0;
      fw_data_q  <= '0;
      s_valid_q  <= 1'b0;
      s_bin_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acq_q      <= acq_d;
      p_valid_q  <= accept;
      p_bin_q    <= tdc_bin;
      fw_valid_q <= rmw_wen;
      fw_bin_q   <= p_bin_q;
      fw_data_q  <= inc_data;
      s_valid_q  <= ren && (state_q == StScan);
      s_bin_q    <= raddr;
      if (start_ok) begin
        ovf_q <= 1'b0;
      end else if (rmw_wen && at_max) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;

  sifh_peak_tracker #(
    .NB     (NB),
    .PEAK_W (PEAK_W)
  ) u_peak (
    .clk        (clk),
    .rst_n      (res),
    .clear      (start_ok),
    .valid      (s_valid_q && !abort),
    .bin        (s_bin_q),
    .count      (rdata),
    .peak_bin   (peak_bin),
    .peak_count (peak_count)
  );

endmodule

// File: tb/tb_sifh_hist_seq.sv
// Directed bench for sifh_hist_seq with a behavioural 16 x 3-bit RAM on its ports.
module tb_sifh_hist_seq;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic       abort;
  logic [23:0] acq_cycles;
  logic       tdc_valid;
  logic [3:0] tdc_bin;
  logic [3:0] waddr;
  logic [2:0] wdata;
  logic       wen;
  logic [3:0] raddr;
  logic       ren;
  logic [2:0] rdata;
  logic       busy;
  logic       done;
  logic [3:0] peak_bin;
  logic [2:0] peak_count;
  logic       ovf;

  logic [2:0] mem [0:15];
  logic       preload = 1'b0;
  int         wr_cnt = 0;
  int         wr_nz = 0;
  int         done_cnt = 0;
  int         bad_port = 0;

  int         n_cmp = 0;
  int         n_bad = 0;

  logic       ev_v [0:63];
  logic [3:0] ev_b [0:63];

  always #5 clk = ~clk;

  sifh_hist_seq #(
    .NB     (4),
    .PEAK_W (3)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .abort      (abort),
    .acq_cycles (acq_cycles),
    .tdc_valid  (tdc_valid),
    .tdc_bin    (tdc_bin),
    .waddr      (waddr),
    .wdata      (wdata),
    .wen        (wen),
    .raddr      (raddr),
    .ren        (ren),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .peak_bin   (peak_bin),
    .peak_count (peak_count),
    .ovf        (ovf)
  );

  // RAM read-during-write returns the old word, so the DUT must forward.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 3'd6;
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
    if (ren) rdata <= mem[raddr];
    if (wen) begin
      wr_cnt <= wr_cnt + 1;
      if (wdata != 3'd0) wr_nz <= wr_nz + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if ((wen || ren) && !busy) bad_port <= bad_port + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 64; i++) begin
      ev_v[i] = 1'b0;
      ev_b[i] = 4'd0;
    end
  endtask

  task automatic set_ev(input int k, input int b);
    ev_v[k] = 1'b1;
    ev_b[k] = 4'(b);
  endtask

  // n counts edges after the one that accepts start; ACQ slot k is driven at n = 16 + k.
  // Stray events go to bin 5 in CLEAR (n = 5) and in the cycle after the window.
  task automatic measure(input string tag, input int acq, input int exp_done,
                         input int poke_n, input int stop_n);
    int got;
    int k;
    got        = -1;
    acq_cycles = 24'(acq);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check_eq({tag, "_busy_on_start"}, busy, 1);
    for (int n = 0; n < 200 && got < 0; n++) begin
      if (n == stop_n) return;
      if (done) got = n;
      k         = n - 16;
      start     = (n == poke_n);
      tdc_valid = 1'b0;
      tdc_bin   = 4'd0;
      if (k >= 0 && k < acq) begin
        tdc_valid = ev_v[k];
        tdc_bin   = ev_b[k];
      end else if (n == 5 || k == acq) begin
        tdc_valid = 1'b1;
        tdc_bin   = 4'd5;
      end
      tick();
    end
    start     = 1'b0;
    tdc_valid = 1'b0;
    check_eq({tag, "_done_cycle"}, got, exp_done);
    check_eq({tag, "_idle_after_done"}, busy, 0);
    check_eq({tag, "_done_1cyc"}, done, 0);
  endtask

  int w0, nz0, d0;
  logic [3:0] pb0;
  logic [2:0] pc0;

  initial begin
    res        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    acq_cycles = 24'd0;
    tdc_valid  = 1'b0;
    tdc_bin    = 4'd0;
    clear_ev();
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wen", wen, 0);
    check_eq("rst_ren", ren, 0);
    check_eq("rst_peak_bin", peak_bin, 0);
    check_eq("rst_peak_count", peak_count, 0);
    check_eq("rst_ovf", ovf, 0);
    res     = 1'b1;
    preload = 1'b1;
    tick();
    preload = 1'b0;

    // Zero-length window: 16 zero writes, no ACQ writes, empty-histogram peak.
    w0  = wr_cnt;
    nz0 = wr_nz;
    d0  = done_cnt;
    measure("acq0", 0, 34, -1, -1);
    check_eq("acq0_writes", wr_cnt - w0, 16);
    check_eq("acq0_nonzero_writes", wr_nz - nz0, 0);
    check_eq("acq0_mem5", mem[5], 0);
    check_eq("acq0_mem15", mem[15], 0);
    check_eq("acq0_peak_bin", peak_bin, 0);
    check_eq("acq0_peak_count", peak_count, 0);
    check_eq("acq0_done_pulses", done_cnt - d0, 1);

    // Back-to-back hits on bin 3, then bin 7 hit twice three cycles apart.
    clear_ev();
    for (int k = 0; k < 5; k++) set_ev(k, 3);
    set_ev(6, 7);
    set_ev(9, 7);
    measure("b2b", 20, 54, -1, -1);
    check_eq("b2b_mem3", mem[3], 5);
    check_eq("b2b_mem7", mem[7], 2);
    check_eq("b2b_mem5_stray", mem[5], 0);
    check_eq("b2b_peak_bin", peak_bin, 3);
    check_eq("b2b_peak_count", peak_count, 5);
    check_eq("b2b_ovf", ovf, 0);

    // Interleaved tie: bin 9 and bin 2 four hits each, lowest bin wins.
    clear_ev();
    for (int k = 0; k < 8; k++) set_ev(k, (k % 2 == 0) ? 9 : 2);
    measure("tie", 20, 54, -1, -1);
    check_eq("tie_mem2", mem[2], 4);
    check_eq("tie_mem9", mem[9], 4);
    check_eq("tie_peak_bin", peak_bin, 2);
    check_eq("tie_peak_count", peak_count, 4);

    // Saturation at 7 with ten hits.
    clear_ev();
    for (int k = 0; k < 10; k++) set_ev(k, 1);
    measure("sat", 20, 54, -1, -1);
    check_eq("sat_mem1", mem[1], 7);
    check_eq("sat_ovf", ovf, 1);
    check_eq("sat_peak_bin", peak_bin, 1);
    check_eq("sat_peak_count", peak_count, 7);

    // Abort in ACQ slot 3 while a write is in flight.
    clear_ev();
    for (int k = 0; k < 3; k++) set_ev(k, 2);
    d0 = done_cnt;
    measure("abt", 20, 0, -1, 19);
    check_eq("abt_ovf_cleared_by_start", ovf, 0);
    pb0   = peak_bin;
    pc0   = peak_count;
    abort = 1'b1;
    #1;
    check_eq("abt_wen_gated", wen, 0);
    check_eq("abt_ren_gated", ren, 0);
    tick();
    abort     = 1'b0;
    tdc_valid = 1'b0;
    check_eq("abt_idle_next", busy, 0);
    check_eq("abt_wen_idle", wen, 0);
    check_eq("abt_peak_bin_kept", peak_bin, pb0);
    check_eq("abt_peak_count_kept", peak_count, pc0);
    repeat (60) tick();
    check_eq("abt_no_done", done_cnt - d0, 0);

    clear_ev();
    for (int k = 0; k < 3; k++) set_ev(k, 4);
    measure("fresh", 10, 44, -1, -1);
    check_eq("fresh_mem4", mem[4], 3);
    check_eq("fresh_mem1_cleared", mem[1], 0);
    check_eq("fresh_peak_bin", peak_bin, 4);
    check_eq("fresh_peak_count", peak_count, 3);

    // start pulsed during SCAN must not disturb the run.
    clear_ev();
    set_ev(0, 6);
    set_ev(1, 6);
    d0 = done_cnt;
    measure("poke", 5, 39, 25, -1);
    check_eq("poke_done_pulses", done_cnt - d0, 1);
    check_eq("poke_peak_bin", peak_bin, 6);
    check_eq("poke_peak_count", peak_count, 2);

    // Reset low during SCAN of a saturated run.
    clear_ev();
    for (int k = 0; k < 9; k++) set_ev(k, 1);
    d0 = done_cnt;
    measure("rst", 12, 0, -1, 32);
    tdc_valid = 1'b0;
    check_eq("rst_scan_busy", busy, 1);
    check_eq("rst_scan_ovf", ovf, 1);
    res = 1'b0;
    #1;
    check_eq("rstm_busy", busy, 0);
    check_eq("rstm_done", done, 0);
    check_eq("rstm_wen", wen, 0);
    check_eq("rstm_ren", ren, 0);
    check_eq("rstm_waddr", waddr, 0);
    check_eq("rstm_raddr", raddr, 0);
    check_eq("rstm_wdata", wdata, 0);
    check_eq("rstm_peak_bin", peak_bin, 0);
    check_eq("rstm_peak_count", peak_count, 0);
    check_eq("rstm_ovf", ovf, 0);
    tick();
    res = 1'b1;
    repeat (50) tick();
    check_eq("rstm_no_done", done_cnt - d0, 0);
    check_eq("rstm_stays_idle", busy, 0);

    check_eq("port_activity_only_when_busy", bad_port, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
